// File: rtl/action_merger_rbttx_pkg.sv
// Shared PHV layout and lookup-response field definitions for the action merger.
// Byte containers sit at the bottom of the PHV vector, then halfwords, then words.
package action_merger_rbttx_pkg;

  localparam int PHV_B_COUNT  = 7;
  localparam int PHV_H_COUNT  = 2;
  localparam int PHV_W_COUNT  = 10;
  localparam int PHV_WIDTH    = 8 * PHV_B_COUNT + 16 * PHV_H_COUNT + 32 * PHV_W_COUNT;
  localparam int ACTION_WIDTH = 32;
  localparam int FIFO_DEPTH   = 16;
  localparam logic [7:0] DEFAULT_PORT = 8'hFF;

  // Byte container indices
  localparam int PKT_PROPERTY_NO = 0;
  localparam int PKT_VALID_NO    = 1;
  localparam int INPORT_NO       = 2;
  localparam int OUTPORT_NO      = 3;
  localparam int TID_NO          = 5;

  // Bit positions inside the PKT_VALID / PKT_PROPERTY bytes
  localparam int PKT_VALID_BIT   = 0;

  // Action data field offsets
  localparam int ACT_OUTPORT_LSB = 0;
  localparam int ACT_DROP_BIT    = 8;
  localparam int ACT_TID_EN_BIT  = 9;
  localparam int ACT_TID_LSB     = 16;

  function automatic int byte_lsb(input int idx);
    return 8 * idx;
  endfunction

  typedef struct packed {
    logic                    hit;
    logic [ACTION_WIDTH-1:0] action;
  } rsp_t;

endpackage

// File: rtl/phv_fifo_rbttx.sv
// Synchronous FIFO holding PHVs while their lookup is outstanding.
// Registered write: a word pushed in cycle N is readable from cycle N+1.
module phv_fifo_rbttx #(
  parameter int WIDTH = 408,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == (AW + 1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // NOTE: storage has no reset; only pointers/occupancy define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/action_merger_rbttx.sv
// Pairs each held PHV with its in-order lookup response and writes the action result back.
// Optional hit/miss statistics counters are built when ACTION_MERGER_STAT_EN is defined.
module action_merger_rbttx
  import action_merger_rbttx_pkg::*;
#(
  parameter int         DEPTH    = FIFO_DEPTH,
  parameter logic [7:0] DEF_PORT = DEFAULT_PORT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PHV_WIDTH-1:0]    s_phv_info,
  input  logic                    s_phv_valid,
  output logic                    s_phv_ready,
  input  logic                    s_rsp_hit,
  input  logic [ACTION_WIDTH-1:0] s_rsp_action,
  input  logic                    s_rsp_valid,
  output logic                    s_rsp_ready,
  output logic [PHV_WIDTH-1:0]    m_phv_info,
  output logic                    m_phv_valid,
  input  logic                    m_phv_ready,
  output logic [31:0]             stat_hit_cnt,
  output logic [31:0]             stat_miss_cnt
);

  localparam int OUTPORT_LSB = byte_lsb(OUTPORT_NO);
  localparam int VALID_BIT   = byte_lsb(PKT_VALID_NO) + PKT_VALID_BIT;
  localparam int TID_LSB     = byte_lsb(TID_NO);

  logic [PHV_WIDTH-1:0] head_phv;
  logic [PHV_WIDTH-1:0] merged;
  logic                 fifo_full, fifo_empty;
  logic                 out_adv, rsp_fire;
  rsp_t                 rsp;
  logic [PHV_WIDTH-1:0] m_phv_info_q, m_phv_info_d;
  logic                 m_phv_valid_q, m_phv_valid_d;
  logic                 unused_act;

  assign rsp        = '{hit: s_rsp_hit, action: s_rsp_action};
  assign unused_act = ^{s_rsp_action[31:24], s_rsp_action[15:10]};

  phv_fifo_rbttx #(
    .WIDTH (PHV_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (s_phv_valid),
    .push_data_i (s_phv_info),
    .pop_i       (rsp_fire),
    .pop_data_o  (head_phv),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign s_phv_ready = !fifo_full;
  assign out_adv     = !m_phv_valid_q || m_phv_ready;
  // A response waiting on an empty FIFO is stalled, never dropped.
  assign s_rsp_ready = !fifo_empty && out_adv;
  assign rsp_fire    = s_rsp_valid && s_rsp_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    merged = head_phv;
    if (rsp.hit) begin
      merged[OUTPORT_LSB +: 8] = rsp.action[ACT_OUTPORT_LSB +: 8];
      if (rsp.action[ACT_DROP_BIT])   merged[VALID_BIT] = 1'b0;
      if (rsp.action[ACT_TID_EN_BIT]) merged[TID_LSB +: 8] = rsp.action[ACT_TID_LSB +: 8];
    end else begin
      merged[OUTPORT_LSB +: 8] = DEF_PORT;
    end
  end

  always_comb begin
    m_phv_info_d  = m_phv_info_q;
    m_phv_valid_d = m_phv_valid_q;
    if (rsp_fire) begin
      m_phv_info_d  = merged;
      m_phv_valid_d = 1'b1;
    end else if (out_adv) begin
      m_phv_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_phv_info_q  <= '0;
      m_phv_valid_q <= 1'b0;
    end else begin
      m_phv_info_q  <= m_phv_info_d;
      m_phv_valid_q <= m_phv_valid_d;
    end
  end

  assign m_phv_info  = m_phv_info_q;
  assign m_phv_valid = m_phv_valid_q;

`ifdef ACTION_MERGER_STAT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rsp_fire) begin
      if (rsp.hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else         miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign stat_hit_cnt  = hit_cnt_q;
  assign stat_miss_cnt = miss_cnt_q;
`else
  assign stat_hit_cnt  = 32'd0;
  assign stat_miss_cnt = 32'd0;
`endif

endmodule
